// File: rtl/inst_mem_responder.sv
// Instruction-fetch memory responder.
// Accepts one fetch request at a time, waits a fixed number of clock edges,
// then presents the addressed 32-bit word until the fetch stage takes it.
// The backing store is a word-addressed array filled through the load port.
module inst_mem_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 3,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] OOR_WORD   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           PC,
    input  logic                  Inst_Req_Valid,
    output logic                  Inst_Req_Ready,
    output logic [31:0]           Instruction,
    output logic                  Inst_Valid,
    input  logic                  Inst_Ready,
    input  logic                  Load_En,
    input  logic [ADDR_WIDTH-1:0] Load_Addr,
    input  logic [31:0]           Load_Data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // The accepting edge counts as the first of LATENCY edges, so the
    // counter starts one below the latency and the read fires at zero.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]            state_reg;
    logic [3:0]            cnt_reg;
    logic [31:0]           req_addr_reg;
    logic [31:0]           instruction_reg;
    logic                  inst_valid_reg;

    logic [31:0]           mem [DEPTH];

    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  out_of_range;

    // Address decode of the latched request; offset wraps modulo 2^32.
    assign offset       = req_addr_reg - BASE_ADDR;
    assign word_idx     = offset[ADDR_WIDTH+1:2];
    assign out_of_range = (req_addr_reg < BASE_ADDR) ||
                          ((offset >> (ADDR_WIDTH + 2)) != 32'd0);

    assign Inst_Req_Ready = (state_reg == ST_IDLE);
    assign Instruction    = instruction_reg;
    assign Inst_Valid     = inst_valid_reg;

    // Loader write port; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (Load_En) begin
            mem[Load_Addr] <= Load_Data;
        end
    end

    // Request/latency/response sequencing with the registered array read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= 4'd0;
            req_addr_reg    <= 32'd0;
            instruction_reg <= 32'd0;
            inst_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (Inst_Req_Valid) begin
                        req_addr_reg <= PC;
                        cnt_reg      <= CNT_INIT;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        // Non-blocking read sees the array before any
                        // load landing on this same edge.
                        instruction_reg <= out_of_range ? OOR_WORD : mem[word_idx];
                        inst_valid_reg  <= 1'b1;
                        state_reg       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (Inst_Ready) begin
                        inst_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    inst_valid_reg <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
Responder end of the instruction-fetch memory interface. It accepts one fetch request (PC) at a time on the request channel. After a fixed, configurable latency it returns the addressed 32-bit word on the response channel and holds it until the fetch stage takes it. Backed by an internal word-addressed ROM-style array, with a bench/loader write port. Used as the I-side memory model behind the fetch stage and as the refill-side stand-in for later cache work.

Parameters:
ADDR_WIDTH, 10, log2 of array depth in 32-bit words (1024 words)
LATENCY, 3, rising edges from request acceptance to response valid; legal range 1..15
BASE_ADDR, 32'h00000000, byte address mapped to word 0
OOR_WORD, 32'h00000013, word returned for out-of-range addresses (RV32 NOP)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
PC  in  32  fetch byte address, sampled on request handshake
Inst_Req_Valid  in  1  initiator has a request
Inst_Req_Ready  out  1  responder can accept a request
Instruction  out  32  returned word
Inst_Valid  out  1  Instruction is valid
Inst_Ready  in  1  initiator accepts response
Load_En  in  1  write enable for array (loader/bench)
Load_Addr  in  ADDR_WIDTH  word index for write
Load_Data  in  32  write data

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE, Inst_Valid=0, Instruction=32'h0, latency counter=0, latched address=0. Array contents are not reset. Reset mid-request discards the request; no response is ever produced for it.
- Inst_Req_Ready = (state==IDLE), combinational from state only. It does not depend on Inst_Req_Valid.
- State IDLE: at an edge with Inst_Req_Valid & Inst_Req_Ready: latch PC into req_addr, load cnt=LATENCY-1, go WAIT. Otherwise stay.
- State WAIT: if cnt!=0, decrement. If cnt==0, read the array, register Instruction, set Inst_Valid=1, go RESP.
- Latency: accepting edge E0, Inst_Valid high immediately after edge E(LATENCY). LATENCY=1 means valid one cycle after acceptance.
- State RESP: Inst_Valid=1; Instruction is held stable while Inst_Ready==0, for any number of cycles. At an edge with Inst_Ready==1: Inst_Valid=0, go IDLE. Instruction keeps its last value (don't-care to the initiator).
- One outstanding request only. Minimum one IDLE cycle between a response handshake and the next request acceptance, so the back-to-back period is LATENCY+2 cycles.
- Address map: off=req_addr-BASE_ADDR (32-bit wrap). Word index = off[ADDR_WIDTH+1:2]. req_addr[1:0] is ignored (no misalignment fault).
- Out-of-range: if req_addr<BASE_ADDR, or off>>2 >= 2^ADDR_WIDTH, return OOR_WORD. No array access.
- Load port: at any edge with Load_En, array[Load_Addr]<=Load_Data, in any state. The read happens at the edge entering RESP and is read-before-write: a write to the same index at that edge is not visible in this response, but is visible to the next request.
- Inst_Ready while not in RESP is ignored. Inst_Req_Valid outside IDLE is ignored; the initiator must hold it, and it is not queued.
- No X on outputs after reset. Illegal state encoding recovers to IDLE.

Test Plan:
- Load word 5=32'h00A00093. With LATENCY=3, request PC=0x14 at edge E0, Inst_Ready=1 -> Inst_Valid high after E3 with Instruction=0x00A00093, low after E4; Inst_Req_Ready high again after E4.
- Same request, Inst_Ready held 0 for 6 cycles then 1 -> Instruction/Inst_Valid stable for all 6 cycles; drop on the edge where Inst_Ready=1.
- PC=0x00001000 (index 1024, ADDR_WIDTH=10), and separately BASE_ADDR=0x100 with PC=0x80 -> both return 32'h00000013.
- PC=0x17 with word 5 loaded -> returns word 5. Load_En to index 5 with 0xDEADBEEF on the RESP-entry edge -> current response shows the old word, next fetch of 0x14 returns 0xDEADBEEF.
- Assert rst=0 asynchronously mid-WAIT -> Inst_Valid=0 and Inst_Req_Ready=1 after release; no stale response appears.
- LATENCY=1, continuous Inst_Req_Valid/Inst_Ready, PCs 0,4,8 -> responses on a 3-cycle period, in order, words 0,1,2.
